pipe_skid_stage: RTL and testbench

- Parametrised, elastic successor to the fixed IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.
- Carries one opaque packed payload of DATA_W bits between two pipeline stages using a valid/ready handshake.
- Holds up to DEPTH entries in an internal circular buffer, so a downstream stall does not need a combinational ready path back to the upstream stage.
- Supports a synchronous flush for exceptions and branch redirects, and counts stall cycles for performance debug.

---
 rtl/pipe_skid_stage_if.sv | 10 +
 rtl/pipe_skid_stage.sv | 59 +++++
 tb/tb_pipe_skid_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if: valid/ready payload handshake between adjacent pipeline stages.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;
  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic pipeline register with a DEPTH-entry circular buffer,
// synchronous flush and a saturating stall counter.
module pipe_skid_stage #(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 2,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter int                CNT_W      = 16,
  localparam int               OCC_W      = $clog2(DEPTH + 1),
  localparam int               PTR_W      = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_skid_stage_if.slave       s_in,
  pipe_skid_stage_if.master      m_out,
  input  logic                   i_flush,
  input  logic                   i_stall_clr,
  output logic [OCC_W-1:0]       o_occupancy,
  output logic [CNT_W-1:0]       o_stall_cnt
);
  logic [DATA_W-1:0] r_buf [DEPTH];
  logic [PTR_W-1:0]  r_rp, r_wp;
  logic [OCC_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_stall;
  logic              w_full, w_empty, w_wr, w_rd;
  logic [PTR_W-1:0]  w_rp_nxt, w_wp_nxt;
  assign w_full   = r_occ == OCC_W'(DEPTH);
  assign w_empty  = r_occ == '0;
  assign w_wr     = s_in.valid & ~w_full & ~i_flush;
  assign w_rd     = ~w_empty & m_out.ready & ~i_flush;
  // explicit wrap since DEPTH need not be a power of two
  assign w_rp_nxt = r_rp == PTR_W'(DEPTH - 1) ? '0 : r_rp + PTR_W'(1);
  assign w_wp_nxt = r_wp == PTR_W'(DEPTH - 1) ? '0 : r_wp + PTR_W'(1);
  assign s_in.ready  = ~w_full;
  assign m_out.valid = ~w_empty;
  assign m_out.data  = w_empty ? RESET_DATA : r_buf[r_rp];
  assign o_occupancy = r_occ;
  assign o_stall_cnt = r_stall;
  always_ff @(posedge clk)
    if (w_wr) r_buf[r_wp] <= s_in.data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_occ   <= '0;
      r_stall <= '0;
    end else begin
      r_rp    <= i_flush ? '0 : w_rd ? w_rp_nxt : r_rp;
      r_wp    <= i_flush ? '0 : w_wr ? w_wp_nxt : r_wp;
      r_occ   <= i_flush ? '0 : (w_wr & ~w_rd) ? r_occ + OCC_W'(1) :
                 (~w_wr & w_rd) ? r_occ - OCC_W'(1) : r_occ;
      r_stall <= i_stall_clr ? '0 :
                 (~w_empty & ~m_out.ready & ~i_flush & ~&r_stall) ? r_stall + CNT_W'(1) : r_stall;
    end
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n) int'(r_occ) <= DEPTH);
  a_ptr_occ: assert property (@(posedge clk) disable iff (!rst_n)
    ((int'(r_wp) - int'(r_rp) + DEPTH) % DEPTH) == (int'(r_occ) % DEPTH));
  a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n) w_wr |-> !w_full);
  a_no_unf: assert property (@(posedge clk) disable iff (!rst_n) w_rd |-> !w_empty);
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: drives DEPTH=1..4 stages with shared stimulus and checks them
// against queue-based reference models.
module tb_pipe_skid_stage;
  localparam logic [15:0] RD = 16'h5A5A;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, stall_clr = 1'b0;
  logic [15:0] in_data = '0;
  logic        ov [4], ir [4];
  logic [15:0] od [4], sc [4];
  logic [2:0]  occ [4];
  logic [15:0] mq [4][$];
  int          msc [4];
  int          passed = 0, total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int D  = g + 1;
    localparam int CW = g == 0 ? 4 : 16;
    pipe_skid_stage_if #(.DATA_W(16)) a ();
    pipe_skid_stage_if #(.DATA_W(16)) b ();
    logic [$clog2(D+1)-1:0] w_occ;
    logic [CW-1:0]          w_sc;
    assign a.valid = in_valid;
    assign a.data  = in_data;
    assign b.ready = out_ready;
    pipe_skid_stage #(.DATA_W(16), .DEPTH(D), .RESET_DATA(RD), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .s_in(a), .m_out(b), .i_flush(flush),
      .i_stall_clr(stall_clr), .o_occupancy(w_occ), .o_stall_cnt(w_sc));
    assign ov[g]  = b.valid;
    assign od[g]  = b.data;
    assign ir[g]  = a.ready;
    assign occ[g] = 3'(w_occ);
    assign sc[g]  = 16'(w_sc);
  end

  function automatic int dep(int k); return k + 1; endfunction
  function automatic int smax(int k); return k == 0 ? 15 : 65535; endfunction

  task automatic tick();
    bit wr [4], rd [4], st [4];
    for (int k = 0; k < 4; k++) begin
      wr[k] = in_valid && mq[k].size() < dep(k) && !flush;
      rd[k] = mq[k].size() != 0 && out_ready && !flush;
      st[k] = mq[k].size() != 0 && !out_ready && !flush;
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (flush) mq[k].delete();
      else begin
        if (rd[k]) void'(mq[k].pop_front());
        if (wr[k]) mq[k].push_back(in_data);
      end
      if (stall_clr) msc[k] = 0;
      else if (st[k] && msc[k] < smax(k)) msc[k]++;
    end
    #1;
  endtask

  task automatic clean();
    flush = 1; stall_clr = 1; in_valid = 0; tick(); flush = 0; stall_clr = 0;
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 4; k++) begin
      total++; if (ov[k] !== 1'b0) $display("FAIL reset_valid[%0d]: got %0b want 0", k, ov[k]); else passed++;
      total++; if (od[k] !== RD) $display("FAIL reset_data[%0d]: got %h want %h", k, od[k], RD); else passed++;
      total++; if (occ[k] !== 3'd0) $display("FAIL reset_occ[%0d]: got %0d want 0", k, occ[k]); else passed++;
      total++; if (sc[k] !== 16'd0) $display("FAIL reset_stall[%0d]: got %0d want 0", k, sc[k]); else passed++;
    end
    rst_n = 1; #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (ir[k] !== 1'b1) $display("FAIL reset_ready[%0d]: got %0b want 1", k, ir[k]); else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    logic [15:0] v [3] = '{16'h11, 16'h22, 16'h33};
    clean(); out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = v[i]; tick();
      total++; if (od[1] !== v[i]) $display("FAIL stream_data[%0d]: got %h want %h", i, od[1], v[i]); else passed++;
      total++; if (occ[1] !== 3'd1) $display("FAIL stream_occ[%0d]: got %0d want 1", i, occ[1]); else passed++;
      total++; if (ir[1] !== 1'b1) $display("FAIL stream_ready[%0d]: got %0b want 1", i, ir[1]); else passed++;
    end
    in_valid = 0; tick();
    total++; if (ov[1] !== 1'b0) $display("FAIL stream_drain: got valid %0b want 0", ov[1]); else passed++;
  endtask

  task automatic test_backpressure();
    logic [15:0] got [$];
    logic [15:0] exp_q [3] = '{16'hA, 16'hB, 16'hC};
    bit acc;
    clean(); out_ready = 0;
    in_valid = 1; in_data = 16'hA; tick();
    in_data = 16'hB; tick();
    in_data = 16'hC; tick();
    total++; if (occ[1] !== 3'd2) $display("FAIL bp_occ: got %0d want 2", occ[1]); else passed++;
    total++; if (ir[1] !== 1'b0) $display("FAIL bp_ready: got %0b want 0", ir[1]); else passed++;
    total++; if (od[1] !== 16'hA) $display("FAIL bp_head: got %h want a", od[1]); else passed++;
    total++; if (sc[1] !== 16'd2) $display("FAIL bp_stall: got %0d want 2", sc[1]); else passed++;
    out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      if (ov[1]) got.push_back(od[1]);
      acc = in_valid && ir[1];
      tick();
      if (acc) in_valid = 0;
    end
    total++; if (got.size() != 3) $display("FAIL bp_count: got %0d want 3", got.size()); else passed++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], exp_q[i]); else passed++;
    end
    total++; if (sc[1] !== 16'd2) $display("FAIL bp_stall_after: got %0d want 2", sc[1]); else passed++;
  endtask

  task automatic test_flush();
    clean(); out_ready = 0;
    for (int i = 1; i <= 3; i++) begin in_valid = 1; in_data = 16'(i); tick(); end
    in_valid = 0;
    total++; if (occ[3] !== 3'd3) $display("FAIL flush_pre_occ: got %0d want 3", occ[3]); else passed++;
    flush = 1; in_valid = 1; in_data = 16'hDEAD; out_ready = 1; tick();
    flush = 0; in_valid = 0;
    total++; if (occ[3] !== 3'd0) $display("FAIL flush_occ: got %0d want 0", occ[3]); else passed++;
    total++; if (ov[3] !== 1'b0) $display("FAIL flush_valid: got %0b want 0", ov[3]); else passed++;
    total++; if (od[3] !== RD) $display("FAIL flush_data: got %h want %h", od[3], RD); else passed++;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (ov[3] !== 1'b0 || od[3] === 16'hDEAD) $display("FAIL flush_leak[%0d]: got %0b/%h want 0/%h", c, ov[3], od[3], RD); else passed++;
    end
  endtask

  task automatic test_wrap();
    clean(); out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1; in_data = 16'(i); tick();
      total++; if (ov[2] !== 1'b1 || od[2] !== 16'(i)) $display("FAIL wrap[%0d]: got %0b/%h want 1/%h", i, ov[2], od[2], 16'(i)); else passed++;
    end
    in_valid = 0; tick();
  endtask

  task automatic test_async_reset();
    clean(); out_ready = 0;
    in_valid = 1; in_data = 16'h5; tick(); in_valid = 0;
    total++; if (ov[0] !== 1'b1 || od[0] !== 16'h5) $display("FAIL ares_full: got %0b/%h want 1/0005", ov[0], od[0]); else passed++;
    #3 rst_n = 0; #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (ov[k] !== 1'b0 || occ[k] !== 3'd0 || od[k] !== RD) $display("FAIL ares_clear[%0d]: got %0b/%0d/%h want 0/0/%h", k, ov[k], occ[k], od[k], RD); else passed++;
      mq[k].delete(); msc[k] = 0;
    end
    #2 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    clean(); out_ready = 0;
    in_valid = 1; in_data = 16'h7; tick(); in_valid = 0;
    repeat (20) tick();
    total++; if (sc[0] !== 16'd15) $display("FAIL sat_stall: got %0d want 15", sc[0]); else passed++;
    total++; if (sc[1] !== 16'd20) $display("FAIL sat_stall_wide: got %0d want 20", sc[1]); else passed++;
    stall_clr = 1; tick(); stall_clr = 0;
    total++; if (sc[0] !== 16'd0) $display("FAIL sat_clr: got %0d want 0", sc[0]); else passed++;
  endtask

  task automatic test_random();
    logic [15:0] ed;
    for (int c = 0; c < 400; c++) begin
      in_valid  = $urandom_range(0, 99) < 65;
      in_data   = 16'($urandom);
      out_ready = $urandom_range(0, 99) < 60;
      flush     = $urandom_range(0, 99) < 5;
      stall_clr = $urandom_range(0, 99) < 3;
      for (int k = 0; k < 4; k++) begin
        ed = mq[k].size() != 0 ? mq[k][0] : RD;
        total++; if (ov[k] !== (mq[k].size() != 0)) $display("FAIL rnd_valid[%0d] c%0d: got %0b want %0b", k, c, ov[k], mq[k].size() != 0); else passed++;
        total++; if (od[k] !== ed) $display("FAIL rnd_data[%0d] c%0d: got %h want %h", k, c, od[k], ed); else passed++;
        total++; if (ir[k] !== (mq[k].size() != dep(k))) $display("FAIL rnd_ready[%0d] c%0d: got %0b want %0b", k, c, ir[k], mq[k].size() != dep(k)); else passed++;
        total++; if (occ[k] !== 3'(mq[k].size())) $display("FAIL rnd_occ[%0d] c%0d: got %0d want %0d", k, c, occ[k], mq[k].size()); else passed++;
        total++; if (sc[k] !== 16'(msc[k])) $display("FAIL rnd_stall[%0d] c%0d: got %0d want %0d", k, c, sc[k], msc[k]); else passed++;
      end
      tick();
    end
    flush = 0; stall_clr = 0; in_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_wrap();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
